// File: rtl/adv7393_pkg.sv
// Shared types, constants and address/interval helpers for the ADV7393 line fetch scheduler.
package adv7393_pkg;

   localparam int LINES_CNT_W  = 10;
   localparam int ADDR_W       = 32;
   localparam int BEATS_W      = 16;
   localparam int LINE_LEN_W   = 16;
   localparam int PIX_PER_BEAT = 4;
   localparam int BUFFER_COUNT = 2;
   localparam int SLOT_W       = $clog2(BUFFER_COUNT);
   localparam int CNT_W        = $clog2(BUFFER_COUNT + 1);

   typedef struct packed {
      logic [ADDR_W-1:0] Base;
      logic [ADDR_W-1:0] LineStep;
   } BufferRegs_t;

   typedef struct packed {
      logic [LINES_CNT_W-1:0] Lines;
      logic [LINE_LEN_W-1:0]  LineLength;
   } FrameRegs_t;

   typedef struct packed {
      logic [LINES_CNT_W-1:0] ActiveLines;
   } StandardRegs_t;

   typedef struct packed {
      BufferRegs_t   buffer;
      FrameRegs_t    frame;
      StandardRegs_t standard;
   } ADV7393RegBlock_t;

   typedef struct packed {
      logic blank;
      logic ready;
   } SlotState_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [BEATS_W-1:0] beats;
      logic [SLOT_W-1:0]  slot;
   } FetchCmd_t;

   typedef struct packed {
      logic                   active;
      logic [LINES_CNT_W-1:0] rel;
   } LineWindow_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_ISSUE
   } FetchState_t;

   // Picture is centred vertically in the standard's active lines; stop is exclusive.
   function automatic LineWindow_t frame_align_center(input ADV7393RegBlock_t regs,
                                                      input logic [LINES_CNT_W-1:0] line_idx);
      logic [LINES_CNT_W-1:0] start;
      logic [LINES_CNT_W:0]   stop;
      LineWindow_t            win;
      start      = (regs.standard.ActiveLines - regs.frame.Lines) >> 1;
      stop       = {1'b0, start} + {1'b0, regs.frame.Lines};
      win.active = (line_idx >= start) && ({1'b0, line_idx} < stop);
      win.rel    = line_idx - start;
      return win;
   endfunction

   function automatic logic [ADDR_W-1:0] line_addr(input ADV7393RegBlock_t regs,
                                                   input logic fb_sel,
                                                   input logic [LINES_CNT_W-1:0] rel);
      logic [ADDR_W-1:0] frame_off;
      logic [ADDR_W-1:0] line_off;
      frame_off = fb_sel ? ADDR_W'(regs.frame.Lines) * regs.buffer.LineStep : '0;
      line_off  = ADDR_W'(rel) * regs.buffer.LineStep;
      return regs.buffer.Base + frame_off + line_off;
   endfunction

   function automatic logic [BEATS_W-1:0] line_beats(input logic [LINE_LEN_W-1:0] len);
      logic [LINE_LEN_W:0] padded;
      padded = {1'b0, len} + (LINE_LEN_W+1)'(PIX_PER_BEAT - 1);
      return BEATS_W'(padded / (LINE_LEN_W+1)'(PIX_PER_BEAT));
   endfunction

endpackage

// File: rtl/adv7393_slot_ring.sv
// Line-buffer slot ring: allocation, DMA completion marking and output-side pop.
module adv7393_slot_ring
   import adv7393_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc,
   input  logic              alloc_blank,
   input  logic              mark_ready,
   input  logic              pop,
   output logic [SLOT_W-1:0] wr_ptr,
   output logic [SLOT_W-1:0] rd_ptr,
   output logic [CNT_W-1:0]  count,
   output SlotState_t        head
);

   SlotState_t        slots [BUFFER_COUNT];
   logic [SLOT_W-1:0] ready_idx;
   logic              ready_hit;
   logic              pop_ok;

   assign head   = slots[rd_ptr];
   assign pop_ok = pop && (count != '0);

   // Walk from the youngest to the oldest so the oldest pending fetch wins.
   always_comb begin
      ready_hit = 1'b0;
      ready_idx = rd_ptr;
      for (int i = BUFFER_COUNT - 1; i >= 0; i--) begin
         if ((i < int'(count)) && !slots[rd_ptr + SLOT_W'(i)].blank
                               && !slots[rd_ptr + SLOT_W'(i)].ready) begin
            ready_hit = 1'b1;
            ready_idx = rd_ptr + SLOT_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // NOTE: only two flag pairs, so they are reset; head then reads a defined value when empty.
         for (int i = 0; i < BUFFER_COUNT; i++) slots[i] <= '0;
      end else begin
         if (mark_ready && ready_hit) slots[ready_idx].ready <= 1'b1;
         if (alloc) begin
            slots[wr_ptr] <= '{blank: alloc_blank, ready: alloc_blank};
            wr_ptr        <= wr_ptr + SLOT_W'(1);
         end
         if (pop_ok) rd_ptr <= rd_ptr + SLOT_W'(1);
         case ({alloc, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/adv7393_fetch_scheduler.sv
// Per-line fetch scheduler: classifies lines, issues DMA read commands, tracks slots and buffer swaps.
module adv7393_fetch_scheduler
   import adv7393_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  ADV7393RegBlock_t       regs,
   input  logic                   frame_start,
   input  logic                   line_req,
   input  logic [LINES_CNT_W-1:0] line_idx,
   input  logic                   fb_swap_req,
   output logic                   fb_sel,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [ADDR_W-1:0]      cmd_addr,
   output logic [BEATS_W-1:0]     cmd_beats,
   output logic [SLOT_W-1:0]      cmd_slot,
   input  logic                   fetch_done,
   input  logic                   line_out_start,
   output logic [SLOT_W-1:0]      rd_slot,
   output logic                   rd_blank,
   input  logic                   consumed,
   output logic                   underrun,
   output logic                   overflow
);

   FetchState_t            state;
   FetchState_t            next_state;
   LineWindow_t            win;
   FetchCmd_t              cmd_q;
   logic [LINES_CNT_W-1:0] rel_q;
   logic                   fb_q;
   logic                   swap_pending;
   logic                   ring_full;
   logic                   req_ok;
   logic                   req_drop;
   logic                   req_fetch;
   logic                   alloc;
   logic [SLOT_W-1:0]      wr_ptr;
   logic [SLOT_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]       count;
   SlotState_t             head;

   assign win       = frame_align_center(regs, line_idx);
   assign ring_full = (count == CNT_W'(BUFFER_COUNT));
   assign req_ok    = line_req && enable && (state == ST_IDLE) && !ring_full;
   assign req_drop  = line_req && enable && ((state != ST_IDLE) || ring_full);
   assign req_fetch = req_ok && win.active;
   assign alloc     = req_ok;

   assign cmd_addr  = cmd_q.addr;
   assign cmd_beats = cmd_q.beats;
   assign cmd_slot  = cmd_q.slot;

   adv7393_slot_ring u_ring (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc       (alloc),
      .alloc_blank (!win.active),
      .mark_ready  (fetch_done),
      .pop         (consumed),
      .wr_ptr      (wr_ptr),
      .rd_ptr      (rd_ptr),
      .count       (count),
      .head        (head)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (req_fetch) next_state = ST_CALC;
         ST_CALC:  next_state = ST_ISSUE;
         ST_ISSUE: if (cmd_ready) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_valid = (state == ST_ISSUE);
   end

   // fb_q captures the front buffer at acceptance so a later swap cannot move this line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q <= '0;
         rel_q <= '0;
         fb_q  <= 1'b0;
      end else begin
         if (req_fetch) begin
            rel_q      <= win.rel;
            fb_q       <= fb_sel;
            cmd_q.slot <= wr_ptr;
         end
         if (state == ST_CALC) begin
            cmd_q.addr  <= line_addr(regs, fb_q, rel_q);
            cmd_q.beats <= line_beats(regs.frame.LineLength);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_sel       <= 1'b0;
         swap_pending <= 1'b0;
      end else if (frame_start && (swap_pending || fb_swap_req)) begin
         fb_sel       <= ~fb_sel;
         swap_pending <= 1'b0;
      end else if (fb_swap_req) begin
         swap_pending <= 1'b1;
      end
   end

   // An empty or unfetched head is shown as blank; the head stays queued for its fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_slot  <= '0;
         rd_blank <= 1'b0;
         underrun <= 1'b0;
         overflow <= 1'b0;
      end else begin
         overflow <= req_drop;
         underrun <= 1'b0;
         if (line_out_start) begin
            if ((count != '0) && head.ready) begin
               rd_slot  <= rd_ptr;
               rd_blank <= head.blank;
            end else begin
               rd_blank <= 1'b1;
               underrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adv7393_fetch_scheduler.sv
// Directed bench for the ADV7393 fetch scheduler with hand-computed expected values.
module tb_adv7393_fetch_scheduler;
   import adv7393_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   enable;
   ADV7393RegBlock_t       regs;
   logic                   frame_start;
   logic                   line_req;
   logic [LINES_CNT_W-1:0] line_idx;
   logic                   fb_swap_req;
   logic                   fb_sel;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [ADDR_W-1:0]      cmd_addr;
   logic [BEATS_W-1:0]     cmd_beats;
   logic [SLOT_W-1:0]      cmd_slot;
   logic                   fetch_done;
   logic                   line_out_start;
   logic [SLOT_W-1:0]      rd_slot;
   logic                   rd_blank;
   logic                   consumed;
   logic                   underrun;
   logic                   overflow;

   int n_checks = 0;
   int n_fail   = 0;

   adv7393_fetch_scheduler dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .regs           (regs),
      .frame_start    (frame_start),
      .line_req       (line_req),
      .line_idx       (line_idx),
      .fb_swap_req    (fb_swap_req),
      .fb_sel         (fb_sel),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_addr       (cmd_addr),
      .cmd_beats      (cmd_beats),
      .cmd_slot       (cmd_slot),
      .fetch_done     (fetch_done),
      .line_out_start (line_out_start),
      .rd_slot        (rd_slot),
      .rd_blank       (rd_blank),
      .consumed       (consumed),
      .underrun       (underrun),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Request an active line, follow it through CALC and ISSUE, and accept it.
   task automatic issue_line(input string tag, input logic [LINES_CNT_W-1:0] idx,
                             input logic [ADDR_W-1:0] exp_addr, input logic exp_slot);
      line_idx = idx; line_req = 1'b1; tick(); line_req = 1'b0;
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL %s_calc_valid: got %0b want 0", tag, cmd_valid); end
      tick();
      n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %0b want 1", tag, cmd_valid); end
      n_checks++; if (cmd_addr !== exp_addr) begin n_fail++; $display("FAIL %s_addr: got %h want %h", tag, cmd_addr, exp_addr); end
      n_checks++; if (cmd_beats !== 16'd160) begin n_fail++; $display("FAIL %s_beats: got %0d want 160", tag, cmd_beats); end
      n_checks++; if (cmd_slot !== exp_slot) begin n_fail++; $display("FAIL %s_slot: got %0d want %0d", tag, cmd_slot, exp_slot); end
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid_drop: got %0b want 0", tag, cmd_valid); end
   endtask

   // Complete the oldest fetch, output the head line and free it.
   task automatic drain_slot(input string tag, input logic exp_slot);
      fetch_done = 1'b1; tick(); fetch_done = 1'b0;
      line_out_start = 1'b1; tick(); line_out_start = 1'b0;
      n_checks++; if (rd_slot !== exp_slot) begin n_fail++; $display("FAIL %s_rd_slot: got %0d want %0d", tag, rd_slot, exp_slot); end
      n_checks++; if (rd_blank !== 1'b0) begin n_fail++; $display("FAIL %s_rd_blank: got %0b want 0", tag, rd_blank); end
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL %s_underrun: got %0b want 0", tag, underrun); end
      consumed = 1'b1; tick(); consumed = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; frame_start = 1'b0; line_req = 1'b0; line_idx = '0;
      fb_swap_req = 1'b0; cmd_ready = 1'b0; fetch_done = 1'b0; line_out_start = 1'b0; consumed = 1'b0;
      regs.buffer.Base = 32'h0001_0000; regs.buffer.LineStep = 32'h0000_1000;
      regs.frame.Lines = 10'd480; regs.frame.LineLength = 16'd640; regs.standard.ActiveLines = 10'd576;
      #2;
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_valid: got %0b want 0", cmd_valid); end
      n_checks++; if (fb_sel !== 1'b0) begin n_fail++; $display("FAIL rst_fb_sel: got %0b want 0", fb_sel); end
      n_checks++; if (cmd_addr !== 32'h0) begin n_fail++; $display("FAIL rst_cmd_addr: got %h want 0", cmd_addr); end
      n_checks++; if ({cmd_beats, cmd_slot} !== '0) begin n_fail++; $display("FAIL rst_cmd_fields: got %h want 0", {cmd_beats, cmd_slot}); end
      n_checks++; if ({rd_slot, rd_blank, underrun, overflow} !== 4'b0) begin n_fail++; $display("FAIL rst_rd_flags: got %b want 0000", {rd_slot, rd_blank, underrun, overflow}); end
      #10 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fetch();
      issue_line("t1", 10'd48, 32'h0001_0000, 1'b0);
      drain_slot("t1", 1'b0);
   endtask

   task automatic test_backpressure();
      line_idx = 10'd100; line_req = 1'b1; tick(); line_req = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL t2_hold_valid[%0d]: got %0b want 1", i, cmd_valid); end
         n_checks++; if (cmd_addr !== 32'h0004_4000) begin n_fail++; $display("FAIL t2_hold_addr[%0d]: got %h want 00044000", i, cmd_addr); end
         n_checks++; if (cmd_slot !== 1'b1) begin n_fail++; $display("FAIL t2_hold_slot[%0d]: got %0d want 1", i, cmd_slot); end
         tick();
      end
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL t2_accept: got %0b want 0", cmd_valid); end
      drain_slot("t2", 1'b1);
   endtask

   task automatic test_fb_swap();
      fb_swap_req = 1'b1; tick(); fb_swap_req = 1'b0;
      n_checks++; if (fb_sel !== 1'b0) begin n_fail++; $display("FAIL t3_pending: got %0b want 0", fb_sel); end
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      n_checks++; if (fb_sel !== 1'b1) begin n_fail++; $display("FAIL t3_swap: got %0b want 1", fb_sel); end
      issue_line("t3a", 10'd48, 32'h001F_0000, 1'b0);
      drain_slot("t3a", 1'b0);
      fb_swap_req = 1'b1; frame_start = 1'b1; tick(); fb_swap_req = 1'b0; frame_start = 1'b0;
      n_checks++; if (fb_sel !== 1'b0) begin n_fail++; $display("FAIL t3_same_cycle: got %0b want 0", fb_sel); end
      // Swap lands while the line sits in CALC: its address keeps the old front buffer.
      line_idx = 10'd48; line_req = 1'b1; tick(); line_req = 1'b0;
      fb_swap_req = 1'b1; frame_start = 1'b1; tick(); fb_swap_req = 1'b0; frame_start = 1'b0;
      n_checks++; if (fb_sel !== 1'b1) begin n_fail++; $display("FAIL t3_calc_swap_sel: got %0b want 1", fb_sel); end
      n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL t3_calc_swap_valid: got %0b want 1", cmd_valid); end
      n_checks++; if (cmd_addr !== 32'h0001_0000) begin n_fail++; $display("FAIL t3_calc_swap_addr: got %h want 00010000", cmd_addr); end
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      drain_slot("t3b", 1'b1);
   endtask

   task automatic test_blank();
      line_idx = 10'd47; line_req = 1'b1; tick(); line_req = 1'b0;
      n_checks++; if ({cmd_valid, overflow} !== 2'b00) begin n_fail++; $display("FAIL t4_47_first: got %b want 00", {cmd_valid, overflow}); end
      tick();
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL t4_47_valid: got %0b want 0", cmd_valid); end
      line_idx = 10'd528; line_req = 1'b1; tick(); line_req = 1'b0;
      n_checks++; if ({cmd_valid, overflow} !== 2'b00) begin n_fail++; $display("FAIL t4_528_first: got %b want 00", {cmd_valid, overflow}); end
      tick();
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL t4_528_valid: got %0b want 0", cmd_valid); end
      for (int s = 0; s < 2; s++) begin
         line_out_start = 1'b1; tick(); line_out_start = 1'b0;
         n_checks++; if (rd_slot !== SLOT_W'(s)) begin n_fail++; $display("FAIL t4_rd_slot[%0d]: got %0d want %0d", s, rd_slot, s); end
         n_checks++; if (rd_blank !== 1'b1) begin n_fail++; $display("FAIL t4_rd_blank[%0d]: got %0b want 1", s, rd_blank); end
         n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL t4_underrun[%0d]: got %0b want 0", s, underrun); end
         consumed = 1'b1; tick(); consumed = 1'b0;
      end
   endtask

   task automatic test_overflow();
      issue_line("t5a", 10'd60, 32'h001F_C000, 1'b0);
      issue_line("t5b", 10'd61, 32'h001F_D000, 1'b1);
      line_out_start = 1'b1; tick(); line_out_start = 1'b0;
      n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL t5_underrun: got %0b want 1", underrun); end
      n_checks++; if (rd_blank !== 1'b1) begin n_fail++; $display("FAIL t5_underrun_blank: got %0b want 1", rd_blank); end
      tick();
      n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL t5_underrun_pulse: got %0b want 0", underrun); end
      line_idx = 10'd62; line_req = 1'b1; tick(); line_req = 1'b0;
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL t5_overflow: got %0b want 1", overflow); end
      tick();
      n_checks++; if ({overflow, cmd_valid} !== 2'b00) begin n_fail++; $display("FAIL t5_overflow_drop: got %b want 00", {overflow, cmd_valid}); end
      drain_slot("t5a", 1'b0);
      drain_slot("t5b", 1'b1);
   endtask

   task automatic test_busy_enable();
      line_idx = 10'd48; line_req = 1'b1; tick();
      line_idx = 10'd49; tick(); line_req = 1'b0;
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL t7_busy_overflow: got %0b want 1", overflow); end
      n_checks++; if (cmd_addr !== 32'h001F_0000) begin n_fail++; $display("FAIL t7_busy_addr: got %h want 001f0000", cmd_addr); end
      enable = 1'b0; line_idx = 10'd50; line_req = 1'b1; cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      n_checks++; if ({overflow, cmd_valid} !== 2'b00) begin n_fail++; $display("FAIL t7_disabled_issue: got %b want 00", {overflow, cmd_valid}); end
      tick(); line_req = 1'b0; tick();
      n_checks++; if ({overflow, cmd_valid} !== 2'b00) begin n_fail++; $display("FAIL t7_disabled_req: got %b want 00", {overflow, cmd_valid}); end
      drain_slot("t7", 1'b0);
      enable = 1'b1;
      line_out_start = 1'b1; tick(); line_out_start = 1'b0;
      n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL t7_empty_underrun: got %0b want 1", underrun); end
      tick();
   endtask

   task automatic test_reset_mid();
      line_idx = 10'd48; line_req = 1'b1; tick(); line_req = 1'b0; tick();
      n_checks++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL t6_pre_valid: got %0b want 1", cmd_valid); end
      rst_n = 1'b0; #1;
      n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL t6_rst_valid: got %0b want 0", cmd_valid); end
      n_checks++; if (fb_sel !== 1'b0) begin n_fail++; $display("FAIL t6_rst_fb_sel: got %0b want 0", fb_sel); end
      n_checks++; if (cmd_addr !== 32'h0) begin n_fail++; $display("FAIL t6_rst_addr: got %h want 0", cmd_addr); end
      #1 rst_n = 1'b1;
      tick();
      line_out_start = 1'b1; tick(); line_out_start = 1'b0;
      n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL t6_ring_empty: got %0b want 1", underrun); end
      issue_line("t6", 10'd48, 32'h0001_0000, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_backpressure();
      test_fb_swap();
      test_blank();
      test_overflow();
      test_busy_enable();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adv7393_fetch_scheduler.md
Name: adv7393_fetch_scheduler

Overview:
- Sequences per-line frame-buffer reads for the ADV7393 output path.
- The video timing generator pulses a prefetch request per line. The block decides whether the line is active or blank, computes the DDR address from the register block, issues a read command to the AXI read DMA, and tracks a 2-slot line-buffer ring.
- Owns front-buffer selection (fb_sel) and flags underrun/overflow.

Parameters:
- LINES_CNT_W, 10, width of line index (clog2 of 625 lines)
- ADDR_W, 32, address width
- BEATS_W, 16, command length width, in AXI beats
- PIX_PER_BEAT, 4, pixels per M_AXI beat (128 bit)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  scheduling enable
- regs  in  ADV7393RegBlock_t  register block: buffer.Base, buffer.LineStep, frame.Lines, frame.LineLength, standard.ActiveLines
- frame_start  in  1  pulse at first line of frame
- line_req  in  1  pulse: prefetch line line_idx
- line_idx  in  LINES_CNT_W  line to prefetch
- fb_swap_req  in  1  pulse from writer: back buffer complete
- fb_sel  out  1  current front buffer
- cmd_valid  out  1  read command valid
- cmd_ready  in  1  DMA accepts command
- cmd_addr  out  ADDR_W  line start byte address
- cmd_beats  out  BEATS_W  beats to read
- cmd_slot  out  1  destination line-buffer slot
- fetch_done  in  1  pulse: DMA finished the slot given by cmd_slot of the oldest outstanding command
- line_out_start  in  1  pulse: output stage begins a line
- rd_slot  out  1  slot to output
- rd_blank  out  1  output blank_val for this line
- consumed  in  1  pulse: output stage finished rd_slot
- underrun  out  1  one-cycle pulse
- overflow  out  1  one-cycle pulse

Behaviour:
- Reset values: all outputs 0; slot ring empty (wr_ptr=rd_ptr=0, count=0); fb_sel=0; swap_pending=0; FSM=IDLE.
- Active interval:
  - start = (ActiveLines − Lines)/2, integer truncation; stop = start + Lines.
  - Line is active iff start ≤ line_idx < stop. Upper bound is exclusive.
  - rel = line_idx − start.
- Address: cmd_addr = Base + (fb_sel ? Lines*LineStep : 0) + rel*LineStep. All products and sums are truncated to 32 bits.
- Beat count: cmd_beats = ceil(LineLength / PIX_PER_BEAT).
- FSM states:
  - IDLE: on line_req with enable=1:
    - ring full (count=2): pulse overflow, drop the request, stay in IDLE.
    - line blank: allocate slot wr_ptr with blank=1, ready=1; no command; stay in IDLE.
    - line active: latch line_idx; allocate slot with blank=0, ready=0; go to CALC.
  - CALC: register both multiplies and the sum; go to ISSUE.
  - ISSUE: cmd_valid=1 with cmd_addr/cmd_beats/cmd_slot held stable until cmd_ready. The handshake completes on cmd_valid & cmd_ready. Next cycle: IDLE, cmd_valid=0.
- Latency: line_req at cycle T gives cmd_valid at T+2 (T+1 is CALC).
- line_req while not in IDLE: pulse overflow, drop.
- fetch_done sets ready of the oldest not-ready non-blank slot. fetch_done with no such slot is ignored.
- line_out_start:
  - Head slot ready: rd_slot=rd_ptr, rd_blank=slot.blank.
  - Ring empty or head not ready: pulse underrun and drive rd_blank=1. The head is not consumed.
- consumed frees the head slot (rd_ptr++, count−−) if count>0; otherwise ignored.
- Simultaneous allocate and consume in one cycle: count unchanged; both pointers advance.
- Frame-buffer swap:
  - fb_swap_req sets swap_pending.
  - On frame_start with swap_pending (including fb_swap_req in the same cycle): fb_sel toggles and swap_pending clears.
  - A swap never alters an address already latched for CALC/ISSUE.
- enable=0:
  - new line_req ignored without an overflow pulse;
  - a command in ISSUE still completes;
  - fetch_done and consumed are still processed.
- Reset asserted mid-operation: immediate return to reset values; an outstanding DMA command is abandoned. The DMA is reset by the same rst_n.

Decomposition:
- Into adv7393_pkg:
  - typedef SlotState_t {blank, ready};
  - typedef FetchCmd_t {addr, beats, slot};
  - function frame_align_center (active interval, exclusive stop);
  - function line_addr(regs, fb_sel, rel), using regs.buffer.LineStep, not the LINE_STEP constant;
  - constant BUFFER_COUNT.
- One sub-module, adv7393_slot_ring: 2-entry ring with pointers, count, and per-slot state; alloc, mark_ready, pop, head.

Test Plan:
1. Base=0x10000, LineStep=0x1000, Lines=480, ActiveLines=576, LineLength=640, fb_sel=0; line_req idx=48 → cmd_valid at T+2, addr=0x10000, beats=160, slot=0.
2. Same config; idx=100 → addr=0x44000. Hold cmd_ready=0 for 5 cycles → addr and valid stable; accepted on the first cycle cmd_ready=1.
3. Pulse fb_swap_req, then frame_start → fb_sel=1. idx=48 → addr=0x1F0000. fb_swap_req and frame_start in the same cycle → toggles immediately.
4. idx=47 and idx=528 → no cmd_valid. Slots allocated blank; line_out_start gives rd_blank=1 with no underrun.
5. Two active line_req without consumed, then a third → overflow pulse and no command. line_out_start before fetch_done → underrun pulse, rd_blank=1.
6. Assert rst_n=0 during ISSUE → cmd_valid=0 the same cycle, ring empty, fb_sel=0. After release, idx=48 → normal fetch to slot 0.
